// File: rtl/alu_mst_pkg.sv
// alu_mst_pkg
// Shared types and constants for the ALU bus initiator (alu_cmd_master).
//   state_t : initiator FSM states
//   SEL_*   : operation group select encodings
//   OP_A_* / OP_B_* : op codes within group A / group B
//   cmd_t   : latched command (group select, op, operands)
package alu_mst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [1:0] OP_A_AND  = 2'd0;
    localparam logic [1:0] OP_A_NAND = 2'd1;
    localparam logic [1:0] OP_A_OR   = 2'd2;
    localparam logic [1:0] OP_A_XOR  = 2'd3;

    localparam logic [1:0] OP_B_XNOR = 2'd0;
    localparam logic [1:0] OP_B_AND  = 2'd1;
    localparam logic [1:0] OP_B_NOR  = 2'd2;
    localparam logic [1:0] OP_B_OR   = 2'd3;

    typedef struct packed {
        logic       sel;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_mst_sat_cnt.sv
// alu_mst_sat_cnt
// Event counter with selectable overflow behaviour.
//   SATURATE = 0 : wraps from all-ones to zero
//   SATURATE = 1 : holds at all-ones
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the count
//   inc  - count one event this cycle
//   cnt  - current count
module alu_mst_sat_cnt #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            if (SATURATE && (&cnt)) begin
                cnt <= cnt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_master.sv
// alu_cmd_master
// Initiator on the ALU bus: takes one command on the cmd valid/ready port,
// drives a single ALU transaction, captures alu_out/alu_irq ALU_LAT cycles
// after issue and returns them on the rsp valid/ready port.
// Ports:
//   alu_clk, rst              - clock, synchronous active-high reset
//   cmd_valid/ready/sel/op/a/b - command port
//   rsp_valid/ready/data/irq   - response port
//   sw_irq_clr                 - software interrupt clear request
//   alu_enable*, alu_op_*, alu_in_*, alu_irq_clr - ALU drive
//   alu_out, alu_irq           - ALU result and interrupt
//   cmd_cnt (wrapping), irq_cnt (saturating) - statistics
// Build option: ALU_MST_IRQ_AUTOCLR_EN -- when defined, alu_irq_clr pulses
// automatically in the first RESP cycle of an interrupting transaction and
// sw_irq_clr is ignored; otherwise alu_irq_clr is sw_irq_clr delayed 1 cycle.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | enables high for one cycle, op/operands driven
// WAIT  | counting down ALU latency, capture when counter is 0
// RESP  | response valid, waiting for rsp_ready
import alu_mst_pkg::*;

module alu_cmd_master #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             alu_clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_irq,
    input  logic             sw_irq_clr,
    output logic             alu_enable,
    output logic             alu_enable_a,
    output logic             alu_enable_b,
    output logic [1:0]       alu_op_a,
    output logic [1:0]       alu_op_b,
    output logic [7:0]       alu_in_a,
    output logic [7:0]       alu_in_b,
    output logic             alu_irq_clr,
    input  logic [7:0]       alu_out,
    input  logic             alu_irq,
    output logic [CNT_W-1:0] cmd_cnt,
    output logic [CNT_W-1:0] irq_cnt
);

    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    cmd_t       cmd_q;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       capture;
    logic       drive_busy;

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        drive_busy   = 1'b0;
        rsp_valid    = 1'b0;
        alu_enable   = 1'b0;
        alu_enable_a = 1'b0;
        alu_enable_b = 1'b0;
        alu_op_a     = 2'd0;
        alu_op_b     = 2'd0;
        alu_in_a     = 8'd0;
        alu_in_b     = 8'd0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                drive_busy   = 1'b1;
                alu_enable   = 1'b1;
                alu_enable_a = (cmd_q.sel == SEL_A);
                alu_enable_b = (cmd_q.sel == SEL_B);
                state_nxt    = WAIT;
            end
            WAIT: begin
                drive_busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // op and operands stay stable through ISSUE and WAIT
        if (drive_busy) begin
            alu_in_a = cmd_q.a;
            alu_in_b = cmd_q.b;
            if (cmd_q.sel == SEL_A) begin
                alu_op_a = cmd_q.op;
            end else begin
                alu_op_b = cmd_q.op;
            end
        end
    end

    always_ff @(posedge alu_clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            cmd_q       <= '0;
            wait_cnt    <= 4'd0;
            rsp_data    <= 8'd0;
            rsp_irq     <= 1'b0;
            alu_irq_clr <= 1'b0;
        end else begin
            state <= state_nxt;
            // registered so ready stays low for the whole reset cycle
            cmd_ready <= (state_nxt == IDLE);

            if (accept) begin
                cmd_q <= '{sel: cmd_sel, op: cmd_op, a: cmd_a, b: cmd_b};
            end

            if (state == ISSUE) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (capture) begin
                rsp_data <= alu_out;
                rsp_irq  <= alu_irq;
            end

`ifdef ALU_MST_IRQ_AUTOCLR_EN
            alu_irq_clr <= capture && alu_irq;
`else
            alu_irq_clr <= sw_irq_clr;
`endif
        end
    end

`ifdef ALU_MST_IRQ_AUTOCLR_EN
    logic unused_sw_irq_clr;
    assign unused_sw_irq_clr = sw_irq_clr;
`endif

    alu_mst_sat_cnt #(
        .W        (CNT_W),
        .SATURATE (1'b0)
    ) u_cmd_cnt (
        .clk (alu_clk),
        .rst (rst),
        .inc (accept),
        .cnt (cmd_cnt)
    );

    alu_mst_sat_cnt #(
        .W        (CNT_W),
        .SATURATE (1'b1)
    ) u_irq_cnt (
        .clk (alu_clk),
        .rst (rst),
        .inc (capture && alu_irq),
        .cnt (irq_cnt)
    );

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Initiator side of the ALU bus.
- Accepts operation commands on a valid/ready port and drives one ALU transaction per command (enables, op code, operands).
- Samples alu_out and alu_irq after a fixed ALU latency, returns the result on a valid/ready response port, and handles interrupt clearing.
- Sits between a sequencer/CPU-side command source and the ALU block.

Parameters:
- ALU_LAT, 1, cycles from the ISSUE cycle to a valid alu_out (legal range 1..15).
- CNT_W, 8, width of the command and IRQ statistics counters.

Ports:
- alu_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_sel  in  1  0 = operation group A, 1 = operation group B.
- cmd_op  in  2  op code within the selected group.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  8  captured alu_out.
- rsp_irq  out  1  alu_irq was high at capture.
- sw_irq_clr  in  1  software IRQ clear request.
- alu_enable  out  1  ALU global enable.
- alu_enable_a  out  1  group A enable.
- alu_enable_b  out  1  group B enable.
- alu_op_a  out  2  group A op.
- alu_op_b  out  2  group B op.
- alu_in_a  out  8  operand A to ALU.
- alu_in_b  out  8  operand B to ALU.
- alu_irq_clr  out  1  IRQ clear to ALU.
- alu_out  in  8  ALU result.
- alu_irq  in  1  ALU interrupt.
- cmd_cnt  out  CNT_W  accepted commands, wraps.
- irq_cnt  out  CNT_W  captures with alu_irq=1, saturates at all-ones.

Behaviour:
- Reset: all outputs 0 (cmd_ready=0 during reset, 1 the first cycle after), state IDLE, counters 0. Asserting reset mid-transaction abandons it; no response is produced and the ALU outputs drop to 0 on the next edge.
- FSM states are IDLE, ISSUE, WAIT, RESP. A single transaction is in flight; no pipelining.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch sel/op/a/b, increment cmd_cnt, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_enable=1.
  - alu_enable_a=~sel_q, alu_enable_b=sel_q.
  - The selected alu_op_x gets op_q; the other op is 0.
  - alu_in_a=a_q, alu_in_b=b_q.
  - Load the wait counter with ALU_LAT-1, then go to WAIT.
- WAIT:
  - Enables are 0. op and operands are held stable.
  - Counter decrements each cycle. In the cycle where the counter is 0, alu_out goes to rsp_data and alu_irq goes to rsp_irq on that edge, then the state moves to RESP.
  - If alu_irq=1 at capture, irq_cnt increments, saturating at all-ones.
- RESP:
  - rsp_valid=1; rsp_data and rsp_irq are held until rsp_ready. Then go to IDLE.
  - ALU op and operand outputs return to 0 on entry to RESP.
- Latency: accept edge at cycle 0, ISSUE in cycle 1, capture at the end of cycle 1+ALU_LAT, rsp_valid from cycle 2+ALU_LAT. With ALU_LAT=1, rsp_valid is high 3 cycles after accept.
- Back-to-back commands: the next accept happens no earlier than the cycle after the rsp handshake, so throughput is 1 command per ALU_LAT+3 cycles when rsp_ready is held high.
- cmd_cnt wraps from all-ones to 0. irq_cnt holds at all-ones.
- Inputs on the cmd_* port are ignored while cmd_ready=0.
- alu_irq toggling outside the capture cycle has no effect on rsp_irq or irq_cnt.

Optional Feature:
- ALU_MST_IRQ_AUTOCLR_EN defined:
  - alu_irq_clr pulses high for exactly 1 cycle, the first RESP cycle, whenever rsp_irq=1.
  - sw_irq_clr is ignored.
- Not defined:
  - alu_irq_clr = sw_irq_clr registered, i.e. 1 cycle delay.
  - No automatic clear.

Decomposition:
- Shared package alu_mst_pkg holds:
  - state_t enum (IDLE, ISSUE, WAIT, RESP).
  - SEL_A=1'b0 and SEL_B=1'b1 constants.
  - Group A op codes (AND, NAND, OR, XOR) and group B op codes (XNOR, AND, NOR, OR).
  - A cmd_t struct {sel, op, a, b}.
- One sub-module, alu_mst_sat_cnt: a parameterised width counter with inc input and a wrap/saturate mode parameter. It is instantiated twice, once for cmd_cnt (wrap) and once for irq_cnt (saturate).

Test Plan:
- Reset, then cmd sel=0 op=2 a=8'hF0 b=8'h0F with ALU model returning 8'hFF at ALU_LAT=1:
  - ISSUE cycle shows alu_enable=1, alu_enable_a=1, alu_op_a=2.
  - rsp_valid rises 3 cycles after accept with rsp_data=8'hFF, rsp_irq=0, cmd_cnt=1.
- Same command with rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_data stay stable and cmd_ready stays 0.
  - A new cmd_valid is not accepted until the cycle after the rsp handshake.
- ALU model raises alu_irq at capture:
  - rsp_irq=1 and irq_cnt=1.
  - With ALU_MST_IRQ_AUTOCLR_EN, a single 1-cycle alu_irq_clr pulse appears in the first RESP cycle.
  - Without it, no pulse until sw_irq_clr=1, which shows on alu_irq_clr 1 cycle later.
- Assert rst during WAIT:
  - No rsp_valid ever appears.
  - All outputs are 0 the following cycle, and cmd_ready=1 after reset is released.
- Parameter sweeps:
  - With ALU_LAT=4, accept-to-rsp_valid is 6 cycles.
  - 256 commands with CNT_W=8 wrap cmd_cnt to 0.
  - 300 IRQ captures saturate irq_cnt at 8'hFF.
